// File: rtl/dma_pkg.sv
// Shared register map and field positions for the DMA host register file.
// Used by dma_regs and by anything that decodes the same address map.
package dma_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_NDAR   = 3'd2;
    localparam logic [2:0] REG_DAR    = 3'd3;
    localparam logic [2:0] REG_IRQCNT = 3'd4;

    localparam int EN_BIT  = 0;
    localparam int APP_BIT = 1;
    localparam int IE_BIT  = 2;

    localparam int ST_BUSY      = 0;
    localparam int ST_INT       = 1;
    localparam int ST_STATE_LSB = 8;
    localparam int ST_CSR_LSB   = 16;

endpackage

// File: rtl/wb_slave_ack.sv
// One-wait-state Wishbone ack generator with write/read strobes.
// The strobes fire on the edge that raises ack, so data is valid during ack.
module wb_slave_ack (
    input  logic clk,
    input  logic rst_n,
    input  logic cyc,
    input  logic stb,
    input  logic we,
    output logic ack,
    output logic wr_stb,
    output logic rd_stb
);

    logic ack_q, ack_d;
    logic acc;

    always_comb begin
        acc    = cyc & stb & ~ack_q;
        ack_d  = acc;
        wr_stb = acc & we;
        rd_stb = acc & ~we;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ack_q <= 1'b0;
        else        ack_q <= ack_d;
    end

    assign ack = ack_q;

endmodule

// File: rtl/dma_regs.sv
// Host-visible register file in front of the DMA control sequencer.
// Owns ndar/append/enable/ie, counts interrupt events and gates inta_o.
module dma_regs
    import dma_pkg::*;
#(
    parameter int       IRQCNT_W = 16,
    parameter bit       EN_RST   = 1'b0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [2:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic [28:0] ndar,
    output logic        ndar_dirty,
    input  logic        ndar_dirty_clear,
    output logic        append,
    input  logic        append_clear,
    output logic        enable,
    output logic        wb_int_clear,
    input  logic        busy,
    input  logic [31:0] dar,
    input  logic [7:0]  csr,
    input  logic [7:0]  ctrl_state,
    input  logic        wb_int_o,
    output logic        inta_o
);

    logic wr_stb, rd_stb;

    wb_slave_ack u_ack (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_n),
        .cyc    (wb_cyc_i),
        .stb    (wb_stb_i),
        .we     (wb_we_i),
        .ack    (wb_ack_o),
        .wr_stb (wr_stb),
        .rd_stb (rd_stb)
    );

    logic [28:0]         ndar_q, ndar_d;
    logic                dirty_q, dirty_d;
    logic                app_q, app_d;
    logic                en_q, en_d;
    logic                ie_q, ie_d;
    logic                clr_pend_q, clr_pend_d;
    logic                int_clr_q, int_clr_d;
    logic                int_prev_q, int_prev_d;
    logic                inta_q, inta_d;
    logic [IRQCNT_W-1:0] irqcnt_q, irqcnt_d;
    logic [31:0]         rdat_q, rdat_d;

    logic wr_ctrl, wr_stat, wr_ndar, wr_irq, int_rise;

    always_comb begin
        wr_ctrl  = wr_stb & (wb_adr_i == REG_CTRL);
        wr_stat  = wr_stb & (wb_adr_i == REG_STATUS);
        wr_ndar  = wr_stb & (wb_adr_i == REG_NDAR) & (|wb_sel_i);
        wr_irq   = wr_stb & (wb_adr_i == REG_IRQCNT);
        int_rise = wb_int_o & ~int_prev_q;

        // NDAR holds address bits [31:3]; byte lane 0 only carries bits [7:3].
        ndar_d = ndar_q;
        if (wr_ndar) begin
            if (wb_sel_i[0]) ndar_d[4:0]   = wb_dat_i[7:3];
            if (wb_sel_i[1]) ndar_d[12:5]  = wb_dat_i[15:8];
            if (wb_sel_i[2]) ndar_d[20:13] = wb_dat_i[23:16];
            if (wb_sel_i[3]) ndar_d[28:21] = wb_dat_i[31:24];
        end

        // Host sets win over same-cycle clears from ctrl.
        dirty_d = wr_ndar ? 1'b1 : (ndar_dirty_clear ? 1'b0 : dirty_q);
        app_d   = (wr_ctrl & wb_dat_i[APP_BIT]) ? 1'b1 : (append_clear ? 1'b0 : app_q);
        en_d    = wr_ctrl ? wb_dat_i[EN_BIT] : en_q;
        ie_d    = wr_ctrl ? wb_dat_i[IE_BIT] : ie_q;

        // Delay the clear request through the ack cycle so the pulse lands after it.
        clr_pend_d = wr_stat & wb_dat_i[ST_INT];
        int_clr_d  = clr_pend_q;

        int_prev_d = wb_int_o;
        inta_d     = wb_int_o & ie_q;

        irqcnt_d = irqcnt_q;
        if (wr_irq)
            irqcnt_d = '0;
        else if (int_rise && !(&irqcnt_q))
            irqcnt_d = irqcnt_q + 1'b1;

        rdat_d = rdat_q;
        if (rd_stb) begin
            rdat_d = 32'h0;
            case (wb_adr_i)
                REG_CTRL: begin
                    rdat_d[EN_BIT]  = en_q;
                    rdat_d[APP_BIT] = app_q;
                    rdat_d[IE_BIT]  = ie_q;
                end
                REG_STATUS: begin
                    rdat_d[ST_BUSY]                     = busy;
                    rdat_d[ST_INT]                      = wb_int_o;
                    rdat_d[ST_STATE_LSB +: 8]           = ctrl_state;
                    rdat_d[ST_CSR_LSB +: 8]             = csr;
                end
                REG_NDAR:   rdat_d = {ndar_q, 3'b000};
                REG_DAR:    rdat_d = dar;
                REG_IRQCNT: rdat_d = 32'(irqcnt_q);
                default:    rdat_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            ndar_q     <= '0;
            dirty_q    <= 1'b0;
            app_q      <= 1'b0;
            en_q       <= EN_RST;
            ie_q       <= 1'b0;
            clr_pend_q <= 1'b0;
            int_clr_q  <= 1'b0;
            int_prev_q <= 1'b0;
            inta_q     <= 1'b0;
            irqcnt_q   <= '0;
            rdat_q     <= '0;
        end else begin
            ndar_q     <= ndar_d;
            dirty_q    <= dirty_d;
            app_q      <= app_d;
            en_q       <= en_d;
            ie_q       <= ie_d;
            clr_pend_q <= clr_pend_d;
            int_clr_q  <= int_clr_d;
            int_prev_q <= int_prev_d;
            inta_q     <= inta_d;
            irqcnt_q   <= irqcnt_d;
            rdat_q     <= rdat_d;
        end
    end

    assign wb_dat_o     = rdat_q;
    assign wb_err_o     = 1'b0;
    assign ndar         = ndar_q;
    assign ndar_dirty   = dirty_q;
    assign append       = app_q;
    assign enable       = en_q;
    assign wb_int_clear = int_clr_q;
    assign inta_o       = inta_q;

endmodule

// File: tb/tb_dma_regs.sv
// Bench for dma_regs: bus reads push expected data to a scoreboard queue,
// popped and compared when the ack arrives; side outputs checked directly.
module tb_dma_regs;

    localparam int CW = 12;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n = 1'b0;
    logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
    logic [3:0]  wb_sel_i = 4'h0;
    logic [2:0]  wb_adr_i = 3'h0;
    logic [31:0] wb_dat_i = 32'h0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o;
    logic [28:0] ndar;
    logic        ndar_dirty, append, enable, wb_int_clear, inta_o;
    logic        ndar_dirty_clear = 1'b0, append_clear = 1'b0;
    logic        busy = 1'b1, wb_int_o = 1'b0;
    logic [31:0] dar = 32'hDEAD_BEE8;
    logic [7:0]  csr = 8'hC3, ctrl_state = 8'h5A;

    int n_cmp = 0, n_err = 0;
    logic [31:0] sb_q[$];

    always #5 wb_clk_i = ~wb_clk_i;

    dma_regs #(.IRQCNT_W(CW), .EN_RST(1'b0)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n(wb_rst_n),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .ndar(ndar), .ndar_dirty(ndar_dirty), .ndar_dirty_clear(ndar_dirty_clear),
        .append(append), .append_clear(append_clear), .enable(enable),
        .wb_int_clear(wb_int_clear), .busy(busy), .dar(dar), .csr(csr),
        .ctrl_state(ctrl_state), .wb_int_o(wb_int_o), .inta_o(inta_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus access; optional ctrl pulses/int rise land on the register-update edge.
    task automatic bus(input logic we, input logic [2:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [31:0] exp,
                       input logic dclr, input logic aclr, input logic irise);
        int n;
        if (!we) sb_q.push_back(exp);
        @(posedge wb_clk_i); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
        ndar_dirty_clear = dclr; append_clear = aclr;
        if (irise) wb_int_o = 1'b1;
        chk("ack_low_at_strobe", {31'h0, wb_ack_o}, 32'h0);
        @(posedge wb_clk_i); #1;
        ndar_dirty_clear = 1'b0; append_clear = 1'b0;
        n = 1;
        while (!wb_ack_o && n < 8) begin
            @(posedge wb_clk_i); #1;
            n++;
        end
        chk("ack_latency", n, 1);
        if (!we && sb_q.size() > 0) chk($sformatf("rd_adr%0d", adr), wb_dat_o, sb_q.pop_front());
        @(posedge wb_clk_i); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        chk("ack_one_cycle", {31'h0, wb_ack_o}, 32'h0);
    endtask

    task automatic rd(input logic [2:0] adr, input logic [31:0] exp);
        bus(1'b0, adr, 32'h0, 4'hF, exp, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [2:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        bus(1'b1, adr, dat, sel, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #23 wb_rst_n = 1'b1;
        #1;
        chk("rst_ndar", {3'b0, ndar}, 32'h0);
        chk("rst_flags", {28'h0, ndar_dirty, append, enable, inta_o}, 32'h0);
        chk("rst_clr", {30'h0, wb_int_clear, wb_err_o}, 32'h0);
        chk("rst_dato", wb_dat_o, 32'h0);

        rd(3'd0, 32'h0);
        rd(3'd1, 32'h00C3_5A01);
        rd(3'd2, 32'h0);
        rd(3'd3, 32'hDEAD_BEE8);
        rd(3'd4, 32'h0);
        rd(3'd5, 32'h0);
        rd(3'd6, 32'h0);
        rd(3'd7, 32'h0);

        wr(3'd2, 32'h1000_0005, 4'hF);
        chk("ndar_val", {3'b0, ndar}, 32'h0200_0000);
        chk("ndar_dirty_set", {31'h0, ndar_dirty}, 32'h1);
        rd(3'd2, 32'h1000_0000);
        @(posedge wb_clk_i); #1 ndar_dirty_clear = 1'b1;
        @(posedge wb_clk_i); #1 ndar_dirty_clear = 1'b0;
        chk("ndar_dirty_clr", {31'h0, ndar_dirty}, 32'h0);

        bus(1'b1, 3'd2, 32'h0000_AB00, 4'b0010, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("ndar_set_wins", {31'h0, ndar_dirty}, 32'h1);
        rd(3'd2, 32'h1000_AB00);
        wr(3'd5, 32'hFFFF_FFFF, 4'hF);
        rd(3'd5, 32'h0);

        wr(3'd0, 32'h3, 4'hF);
        chk("ctrl_en_app", {30'h0, enable, append}, 32'h3);
        @(posedge wb_clk_i); #1 append_clear = 1'b1;
        @(posedge wb_clk_i); #1 append_clear = 1'b0;
        chk("append_clr", {31'h0, append}, 32'h0);
        rd(3'd0, 32'h1);
        bus(1'b1, 3'd0, 32'h2, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("app_set_wins", {30'h0, enable, append}, 32'h1);
        chk("dirty_kept", {31'h0, ndar_dirty}, 32'h1);
        rd(3'd0, 32'h2);

        wr(3'd0, 32'h4, 4'hF);
        wb_int_o = 1'b1;
        chk("inta_lag0", {31'h0, inta_o}, 32'h0);
        @(posedge wb_clk_i); #1;
        chk("inta_lag1", {31'h0, inta_o}, 32'h1);
        rd(3'd4, 32'h1);
        rd(3'd1, 32'h00C3_5A03);
        wr(3'd1, 32'h2, 4'hF);
        chk("intclr_hi", {31'h0, wb_int_clear}, 32'h1);
        @(posedge wb_clk_i); #1;
        chk("intclr_lo", {31'h0, wb_int_clear}, 32'h0);
        wr(3'd0, 32'h0, 4'hF);
        @(posedge wb_clk_i); #1;
        chk("inta_ie0", {31'h0, inta_o}, 32'h0);
        wb_int_o = 1'b0;

        for (int i = 0; i < (1 << CW) + 4; i++) begin
            @(posedge wb_clk_i); #1 wb_int_o = 1'b1;
            @(posedge wb_clk_i); #1 wb_int_o = 1'b0;
        end
        rd(3'd4, 32'h0000_0FFF);
        wr(3'd4, 32'h0, 4'hF);
        rd(3'd4, 32'h0);
        @(posedge wb_clk_i); #1 wb_int_o = 1'b1;
        @(posedge wb_clk_i); #1 wb_int_o = 1'b0;
        rd(3'd4, 32'h1);
        bus(1'b1, 3'd4, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0, 1'b1);
        rd(3'd4, 32'h0);
        wb_int_o = 1'b0;

        @(posedge wb_clk_i); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = 3'd0;
        @(posedge wb_clk_i); #1;
        wb_rst_n = 1'b0;
        #1;
        chk("rst_mid_ack", {31'h0, wb_ack_o}, 32'h0);
        chk("rst_mid_ndar", {3'b0, ndar}, 32'h0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        #10 wb_rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dma_regs.md
Name: dma_regs

Overview:
- Wishbone slave register file directly upstream of the DMA control sequencer (ctrl).
- Host software programs the next-descriptor address, enable, append and interrupt-enable bits here.
- Produces the ndar/ndar_dirty/append/enable/wb_int_clear handshakes that ctrl consumes.
- Reads back ctrl status (busy, dar, csr, state, interrupt) and gates the interrupt to the host.

Parameters:
- IRQCNT_W, 16, width of the saturating interrupt event counter.
- EN_RST, 0, reset value of CTRL.enable.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_n  in  1  asynchronous active-low reset
- wb_cyc_i  in  1  WB cycle
- wb_stb_i  in  1  WB strobe
- wb_we_i  in  1  WB write enable
- wb_sel_i  in  4  byte lane selects
- wb_adr_i  in  3  word address [4:2]
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data
- wb_ack_o  out  1  acknowledge
- wb_err_o  out  1  error, tied 0
- ndar  out  29  next descriptor address [31:3]
- ndar_dirty  out  1  NDAR written, not yet taken by ctrl
- ndar_dirty_clear  in  1  one-cycle pulse from ctrl
- append  out  1  append request
- append_clear  in  1  one-cycle pulse from ctrl
- enable  out  1  DMA enable
- wb_int_clear  out  1  one-cycle interrupt clear pulse to ctrl
- busy  in  1  ctrl busy
- dar  in  32  current descriptor address
- csr  in  8  ctrl status
- ctrl_state  in  8  ctrl state (debug)
- wb_int_o  in  1  ctrl interrupt flag
- inta_o  out  1  host interrupt

Behaviour:
- Reset is asynchronous, active-low. Reset values:
  - ndar=0, ndar_dirty=0, append=0, enable=EN_RST, ie=0.
  - wb_int_clear=0, irqcnt=0, wb_ack_o=0, wb_dat_o=0.
- The clock is wb_clk_i and the reset is wb_rst_n; the reset is asynchronous and active-low.
- Bus handshake:
  - wb_ack_o rises one cycle after cyc&stb&!ack and lasts exactly one cycle, so one wait state per access.
  - A back-to-back strobe is acked every other cycle.
  - Register write and read-data capture happen on the cycle that wb_ack_o is asserted.
  - wb_err_o is always 0.
- Address map (word offsets):
  - 0 CTRL: bit0 enable RW; bit1 append W1S, reads current append; bit2 ie RW; other bits read 0.
  - 1 STATUS (RO except bit1): bit0 busy; bit1 wb_int_o; [15:8] ctrl_state; [23:16] csr.
    - Writing 1 to bit1 produces wb_int_clear high for exactly one cycle, the cycle after the ack.
  - 2 NDAR: RW, byte-lane writes per wb_sel_i; bits[2:0] read 0.
    - Any write with a nonzero sel sets ndar_dirty.
  - 3 DAR: RO, equals dar.
  - 4 IRQCNT: RO count of wb_int_o rising edges, saturating at all-ones.
    - Any write clears it to 0.
  - 5-7: read 0, writes ignored, still acked.
- Handshake precedence:
  - A NDAR write in the same cycle as ndar_dirty_clear leaves ndar_dirty=1; the set wins.
  - An append W1S in the same cycle as append_clear leaves append=1.
  - An IRQCNT write in the same cycle as a wb_int_o rising edge gives irqcnt=0; the clear wins.
- NDAR may be written while busy. ctrl samples ndar only in its idle state, so the new value is used on the next start.
- Clearing enable does not clear ndar_dirty or append; they stay pending until ctrl acknowledges them.
- inta_o = wb_int_o & ie, registered, so it lags wb_int_o by one cycle.
- Rising edge is detected against a registered copy of wb_int_o; that copy resets to 0.
- Reset mid-access drops ack immediately. No partial write is retained beyond the reset values.

Decomposition:
- Shared package dma_pkg holds:
  - register offsets REG_CTRL..REG_IRQCNT;
  - CTRL bit indices EN_BIT, APP_BIT, IE_BIT;
  - STATUS field positions.
- Natural sub-module: wb_slave_ack, the one-wait-state ack generator plus the write/read strobe decode.

Test Plan:
- Reset, then read all 8 offsets:
  - CTRL=0x0, NDAR=0, IRQCNT=0, offsets 5-7 = 0;
  - every access acked exactly one cycle after the strobe.
- Write NDAR=0x1000_0005 with sel=4'hF:
  - ndar=0x0200_0000, ndar_dirty=1, readback 0x1000_0000.
  - Pulse ndar_dirty_clear: dirty=0 next cycle.
- Write NDAR with sel=4'b0010 and data 0x0000_AB00 over 0x1000_0000:
  - readback 0x1000_AB00;
  - a write in the same cycle as ndar_dirty_clear leaves dirty=1.
- Write CTRL=0x3, then append_clear one cycle later:
  - enable=1, append=1 then 0;
  - CTRL=0x2 written in the same cycle as append_clear leaves append=1.
- Set ie, toggle wb_int_o 0→1:
  - inta_o=1 one cycle later, IRQCNT=1;
  - write STATUS=0x2: wb_int_clear is a single-cycle pulse; ie=0 forces inta_o=0.
- Force IRQCNT to 0xFFFF with 65536 rising edges: IRQCNT stays 0xFFFF; a write returns it to 0.
